pad_cfg_sequencer: RTL and testbench

Parametrised pad-configuration controller sitting between the management core and the user-project GPIO padframe. Holds a shadow configuration word per pad, written at random by index over a valid/ready port, and on request commits shadow to active pad controls one pad at a time (rolling apply) to bound simultaneous switching on the shared 5V supply. Drives the per-pad OE/IE/PU/PD/CS/SL/PDRV inputs of an array of NUM_PADS bidirectional pads.

---
 rtl/pad_cfg_pkg.sv | 39 +++
 rtl/pad_cfg_slot.sv | 51 +++++
 rtl/pad_cfg_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_pad_cfg_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pad_cfg_pkg
// Shared definitions for the pad configuration sequencer:
//   - CFG_W and the bit positions of the per-pad configuration word
//     [0]oe [1]ie [2]pu [3]pd [4]schmitt [5]slew [7:6]drive
//   - seq_state_e : rolling-commit FSM state encoding
//   - sanitise_cfg: resolves the illegal pull-up + pull-down combination
// -----------------------------------------------------------------------------
package pad_cfg_pkg;

    localparam int CFG_W       = 8;
    localparam int CFG_OE      = 0;
    localparam int CFG_IE      = 1;
    localparam int CFG_PU      = 2;
    localparam int CFG_PD      = 3;
    localparam int CFG_SCHMITT = 4;
    localparam int CFG_SLEW    = 5;
    localparam int CFG_DRV_LSB = 6;
    localparam int CFG_DRV_MSB = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    // Enabling both pulls would fight on the pad; pull-up wins, pull-down is dropped.
    function automatic logic [CFG_W-1:0] sanitise_cfg(input logic [CFG_W-1:0] cfg);
        logic [CFG_W-1:0] res;
        res = cfg;
        if (cfg[CFG_PU] && cfg[CFG_PD]) begin
            res[CFG_PD] = 1'b0;
        end else begin
            res = cfg;
        end
        return res;
    endfunction

endpackage

// File: rtl/pad_cfg_slot.sv
// -----------------------------------------------------------------------------
// pad_cfg_slot
// One pad's configuration storage: a shadow word written by the management
// side and an active word that drives the pad, loaded from shadow on commit.
// Ports:
//   clock, reset    : clock, asynchronous active-high reset (both words -> DEFAULT_CFG)
//   wr_en, wr_data  : load shadow word (wr_data already sanitised)
//   commit_en       : copy shadow into active
//   active_cfg      : active word (direct register output)
// -----------------------------------------------------------------------------
module pad_cfg_slot
    import pad_cfg_pkg::*;
#(
    parameter logic [CFG_W-1:0] DEFAULT_CFG = 8'h02
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CFG_W-1:0] wr_data,
    input  logic             commit_en,
    output logic [CFG_W-1:0] active_cfg
);

    logic [CFG_W-1:0] shadow_r;
    logic [CFG_W-1:0] active_r;

    // Shadow word: updated only by an accepted write to this pad.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_r <= DEFAULT_CFG;
        end else if (wr_en) begin
            shadow_r <= wr_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Active word: takes the shadow value when the rolling commit reaches this pad.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_r <= DEFAULT_CFG;
        end else if (commit_en) begin
            active_r <= shadow_r;
        end else begin
            active_r <= active_r;
        end
    end

    assign active_cfg = active_r;

endmodule

// File: rtl/pad_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// pad_cfg_sequencer
// Pad configuration controller between the management core and the GPIO
// padframe. Shadow words are written by index over a valid/ready port; an
// apply request commits shadow to active one pad every STEP_CYCLES clocks so
// that pad drivers never all switch on the same edge.
// Parameters: NUM_PADS (1..64), STEP_CYCLES (1..16), DEFAULT_CFG.
// Ports:
//   clock, reset               : clock, asynchronous active-high reset
//   cfg_valid/cfg_ready        : write handshake (ready only while idle)
//   cfg_pad, cfg_data          : write target index and configuration word
//   cfg_err                    : one-cycle pulse after a write to an invalid index
//   apply_req                  : start rolling commit (sampled while idle)
//   busy, apply_done           : commit in progress / one-cycle completion pulse
//   pad_oe..pad_slew, pad_drive: active per-pad controls
//   rb_pad, rb_data            : registered readback of an active word
// Build option: define PAD_CFG_READBACK_EN to include rb_pad/rb_data.
// -----------------------------------------------------------------------------
module pad_cfg_sequencer
    import pad_cfg_pkg::*;
#(
    parameter int               NUM_PADS    = 38,
    parameter int               STEP_CYCLES = 1,
    parameter logic [CFG_W-1:0] DEFAULT_CFG = 8'h02,
    localparam int              PAD_IDX_W   = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PAD_IDX_W-1:0]  cfg_pad,
    input  logic [CFG_W-1:0]      cfg_data,
    output logic                  cfg_err,
    input  logic                  apply_req,
    output logic                  busy,
    output logic                  apply_done,
    output logic [NUM_PADS-1:0]   pad_oe,
    output logic [NUM_PADS-1:0]   pad_ie,
    output logic [NUM_PADS-1:0]   pad_pu,
    output logic [NUM_PADS-1:0]   pad_pd,
    output logic [NUM_PADS-1:0]   pad_schmitt,
    output logic [NUM_PADS-1:0]   pad_slew,
    output logic [2*NUM_PADS-1:0] pad_drive
`ifdef PAD_CFG_READBACK_EN
    ,
    input  logic [PAD_IDX_W-1:0]  rb_pad,
    output logic [CFG_W-1:0]      rb_data
`endif
);

    localparam int                   STEP_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0]    STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
    localparam logic [PAD_IDX_W-1:0] PAD_LAST   = PAD_IDX_W'(NUM_PADS - 1);
    localparam logic [PAD_IDX_W:0]   PAD_COUNT  = (PAD_IDX_W + 1)'(NUM_PADS);

    seq_state_e             state_r;
    seq_state_e             state_s;
    logic [PAD_IDX_W-1:0]   pad_idx_r;
    logic [PAD_IDX_W-1:0]   pad_idx_s;
    logic [STEP_W-1:0]      step_r;
    logic [STEP_W-1:0]      step_s;

    logic                   cfg_ready_r;
    logic                   busy_r;
    logic                   apply_done_r;
    logic                   cfg_err_r;

    logic                   wr_fire_s;
    logic                   pad_in_range_s;
    logic                   step_term_s;
    logic [CFG_W-1:0]       wr_data_s;
    logic [CFG_W-1:0]       active_s [NUM_PADS];

    // cfg_ready_r is high exactly in IDLE, so it doubles as the write-accept qualifier.
    assign wr_fire_s      = cfg_valid & cfg_ready_r;
    // Widen by one bit so NUM_PADS itself (e.g. 64) is representable in the compare.
    assign pad_in_range_s = ({1'b0, cfg_pad} < PAD_COUNT);
    assign step_term_s    = (state_r == ST_APPLY) && (step_r == STEP_LAST);
    assign wr_data_s      = sanitise_cfg(cfg_data);

    // Next-state logic for the rolling commit: step counter paces pad index advance.
    always_comb begin
        state_s   = state_r;
        pad_idx_s = pad_idx_r;
        step_s    = step_r;
        case (state_r)
            ST_IDLE: begin
                if (apply_req) begin
                    state_s   = ST_APPLY;
                    pad_idx_s = '0;
                    step_s    = '0;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (step_r == STEP_LAST) begin
                    step_s = '0;
                    if (pad_idx_r == PAD_LAST) begin
                        state_s   = ST_DONE;
                        pad_idx_s = '0;
                    end else begin
                        pad_idx_s = pad_idx_r + PAD_IDX_W'(1);
                    end
                end else begin
                    step_s = step_r + STEP_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                pad_idx_s = '0;
                step_s    = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pad_idx_r <= '0;
            step_r    <= '0;
        end else begin
            state_r   <= state_s;
            pad_idx_r <= pad_idx_s;
            step_r    <= step_s;
        end
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            apply_done_r <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            cfg_ready_r  <= (state_s == ST_IDLE);
            busy_r       <= (state_s == ST_APPLY);
            apply_done_r <= (state_s == ST_DONE);
            cfg_err_r    <= wr_fire_s & ~pad_in_range_s;
        end
    end

    assign cfg_ready  = cfg_ready_r;
    assign busy       = busy_r;
    assign apply_done = apply_done_r;
    assign cfg_err    = cfg_err_r;

    // One storage slot per pad; controls are plain bit-picks of the active registers.
    for (genvar k = 0; k < NUM_PADS; k++) begin : g_slot
        logic slot_we_s;
        logic slot_commit_s;

        assign slot_we_s     = wr_fire_s && pad_in_range_s && (cfg_pad == PAD_IDX_W'(k));
        assign slot_commit_s = step_term_s && (pad_idx_r == PAD_IDX_W'(k));

        pad_cfg_slot #(
            .DEFAULT_CFG (DEFAULT_CFG)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .wr_en      (slot_we_s),
            .wr_data    (wr_data_s),
            .commit_en  (slot_commit_s),
            .active_cfg (active_s[k])
        );

        assign pad_oe[k]          = active_s[k][CFG_OE];
        assign pad_ie[k]          = active_s[k][CFG_IE];
        assign pad_pu[k]          = active_s[k][CFG_PU];
        assign pad_pd[k]          = active_s[k][CFG_PD];
        assign pad_schmitt[k]     = active_s[k][CFG_SCHMITT];
        assign pad_slew[k]        = active_s[k][CFG_SLEW];
        assign pad_drive[2*k+1:2*k] = active_s[k][CFG_DRV_MSB:CFG_DRV_LSB];
    end

`ifdef PAD_CFG_READBACK_EN
    logic [CFG_W-1:0] rb_sel_s;
    logic [CFG_W-1:0] rb_data_r;

    // Readback select; indices beyond NUM_PADS match no slot and read as zero.
    always_comb begin
        rb_sel_s = '0;
        for (int k = 0; k < NUM_PADS; k++) begin
            if (rb_pad == PAD_IDX_W'(k)) begin
                rb_sel_s = active_s[k];
            end else begin
                rb_sel_s = rb_sel_s;
            end
        end
    end

    // Readback register: one cycle of latency from rb_pad.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rb_data_r <= DEFAULT_CFG;
        end else begin
            rb_data_r <= rb_sel_s;
        end
    end

    assign rb_data = rb_data_r;
`endif

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pad_cfg_sequencer
// Directed bench for pad_cfg_sequencer. Instance "dut" uses STEP_CYCLES=1,
// instance "dut_b" uses STEP_CYCLES=4 for the mid-apply reset case.
// Write vectors come from a table; commit timing, reset and request-dropping
// cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pad_cfg_sequencer;

    localparam int NP = 38;

    logic          clock = 1'b0;
    logic          reset, reset_b;
    logic          cfg_valid, cfg_valid_b;
    logic          cfg_ready, cfg_ready_b;
    logic [5:0]    cfg_pad, cfg_pad_b;
    logic [7:0]    cfg_data, cfg_data_b;
    logic          cfg_err, cfg_err_b;
    logic          apply_req, apply_req_b;
    logic          busy, busy_b;
    logic          apply_done, apply_done_b;
    logic [NP-1:0] pad_oe, pad_ie, pad_pu, pad_pd, pad_schmitt, pad_slew;
    logic [NP-1:0] pad_oe_b, pad_ie_b, pad_pu_b, pad_pd_b, pad_schmitt_b, pad_slew_b;
    logic [2*NP-1:0] pad_drive, pad_drive_b;
`ifdef PAD_CFG_READBACK_EN
    logic [5:0]    rb_pad, rb_pad_b;
    logic [7:0]    rb_data, rb_data_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0] pad;
        logic [7:0] data;
        logic       exp_err;
        logic [7:0] exp_word;
    } wr_vec_t;

    wr_vec_t    vecs [6];
    logic [7:0] model [NP];

    always #5 clock = ~clock;

    pad_cfg_sequencer #(.NUM_PADS(NP), .STEP_CYCLES(1), .DEFAULT_CFG(8'h02)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pad(cfg_pad), .cfg_data(cfg_data), .cfg_err(cfg_err), .apply_req(apply_req),
        .busy(busy), .apply_done(apply_done), .pad_oe(pad_oe), .pad_ie(pad_ie),
        .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_schmitt(pad_schmitt), .pad_slew(pad_slew),
        .pad_drive(pad_drive)
`ifdef PAD_CFG_READBACK_EN
        , .rb_pad(rb_pad), .rb_data(rb_data)
`endif
    );

    pad_cfg_sequencer #(.NUM_PADS(NP), .STEP_CYCLES(4), .DEFAULT_CFG(8'h02)) dut_b (
        .clock(clock), .reset(reset_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .cfg_pad(cfg_pad_b), .cfg_data(cfg_data_b), .cfg_err(cfg_err_b), .apply_req(apply_req_b),
        .busy(busy_b), .apply_done(apply_done_b), .pad_oe(pad_oe_b), .pad_ie(pad_ie_b),
        .pad_pu(pad_pu_b), .pad_pd(pad_pd_b), .pad_schmitt(pad_schmitt_b), .pad_slew(pad_slew_b),
        .pad_drive(pad_drive_b)
`ifdef PAD_CFG_READBACK_EN
        , .rb_pad(rb_pad_b), .rb_data(rb_data_b)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word_a(input int k);
        return {pad_drive[2*k+1], pad_drive[2*k], pad_slew[k], pad_schmitt[k],
                pad_pd[k], pad_pu[k], pad_ie[k], pad_oe[k]};
    endfunction

    task automatic do_write(input logic [5:0] p, input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_pad   = p;
        cfg_data  = d;
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic do_write_b(input logic [5:0] p, input logic [7:0] d);
        cfg_valid_b = 1'b1;
        cfg_pad_b   = p;
        cfg_data_b  = d;
        @(posedge clock);
        #1;
        cfg_valid_b = 1'b0;
    endtask

    initial begin
        int n_done;
        logic [NP-1:0] all_ones;
        all_ones = '1;

        vecs[0] = '{pad: 6'd5,  data: 8'hC1, exp_err: 1'b0, exp_word: 8'hC1};
        vecs[1] = '{pad: 6'd3,  data: 8'h0C, exp_err: 1'b0, exp_word: 8'h04};
        vecs[2] = '{pad: 6'd40, data: 8'hFF, exp_err: 1'b1, exp_word: 8'h00};
        vecs[3] = '{pad: 6'd0,  data: 8'h3D, exp_err: 1'b0, exp_word: 8'h35};
        vecs[4] = '{pad: 6'd37, data: 8'h4A, exp_err: 1'b0, exp_word: 8'h4A};
        vecs[5] = '{pad: 6'd63, data: 8'h11, exp_err: 1'b1, exp_word: 8'h00};
        for (int k = 0; k < NP; k++) model[k] = 8'h02;

        reset = 1'b1; reset_b = 1'b1;
        cfg_valid = 1'b0; cfg_pad = '0; cfg_data = '0; apply_req = 1'b0;
        cfg_valid_b = 1'b0; cfg_pad_b = '0; cfg_data_b = '0; apply_req_b = 1'b0;
`ifdef PAD_CFG_READBACK_EN
        rb_pad = '0; rb_pad_b = '0;
`endif
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0; reset_b = 1'b0;

        // Reset state
        check("rst_ie", pad_ie, all_ones);
        check("rst_oe", pad_oe, '0);
        check("rst_pu_pd", {pad_pu, pad_pd}, '0);
        check("rst_schmitt_slew", {pad_schmitt, pad_slew}, '0);
        check("rst_drive", pad_drive, '0);
        check("rst_status", {cfg_ready, busy, apply_done, cfg_err}, 4'b1000);
`ifdef PAD_CFG_READBACK_EN
        check("rst_rb", rb_data, 8'h02);
`endif

        // Table of writes: error pulse next cycle, then cleared
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].pad, vecs[i].data);
            check($sformatf("wr%0d_err", i), cfg_err, vecs[i].exp_err);
            if (!vecs[i].exp_err) model[vecs[i].pad] = vecs[i].exp_word;
            @(posedge clock);
            #1;
            check($sformatf("wr%0d_err_clr", i), cfg_err, 1'b0);
        end
        check("no_commit_before_apply", pad_oe, '0);

        // Rolling apply with STEP_CYCLES=1
        apply_req = 1'b1;
        @(posedge clock);
        #1;
        apply_req = 1'b0;
        check("apply_busy_t0", {busy, cfg_ready}, 2'b10);
        for (int c = 1; c <= NP; c++) begin
            @(posedge clock);
            #1;
            if (c == 1)  check("pad0_commit", word_a(0), 8'h35);
            if (c == 5)  check("pad5_before", pad_oe[5], 1'b0);
            if (c == 6)  check("pad5_after", {pad_oe[5], pad_drive[11:10]}, 3'b111);
            if (c == NP - 1) check("pre_done", {apply_done, busy}, 2'b01);
            if (c == NP) check("done_pulse", {apply_done, busy, cfg_ready}, 3'b100);
        end
        @(posedge clock);
        #1;
        check("back_idle", {apply_done, busy, cfg_ready}, 3'b001);
        for (int k = 0; k < NP; k++) check($sformatf("word%0d", k), word_a(k), model[k]);
        check("pad3_pulls", {pad_pu[3], pad_pd[3]}, 2'b10);
`ifdef PAD_CFG_READBACK_EN
        rb_pad = 6'd5;
        @(posedge clock);
        #1;
        check("rb_pad5", rb_data, 8'hC1);
        rb_pad = 6'd40;
        @(posedge clock);
        #1;
        check("rb_oob", rb_data, 8'h00);
`endif

        // Write and apply in the same cycle; repeat requests while busy are dropped
        cfg_valid = 1'b1; cfg_pad = 6'd10; cfg_data = 8'h81; apply_req = 1'b1;
        @(posedge clock);
        #1;
        cfg_valid = 1'b0; apply_req = 1'b0;
        model[10] = 8'h81;
        check("same_cycle_busy", busy, 1'b1);
        n_done = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c >= 5 && c <= 10) begin
                apply_req = 1'b1; cfg_valid = 1'b1; cfg_pad = 6'd11; cfg_data = 8'hFF;
            end else begin
                apply_req = 1'b0; cfg_valid = 1'b0;
            end
            @(posedge clock);
            #1;
            if (apply_done) n_done++;
        end
        check("single_done", n_done, 1);
        check("idle_after", {busy, cfg_ready}, 2'b01);
        check("pad10_word", word_a(10), 8'h81);
        check("pad11_ignored", word_a(11), model[11]);

        // STEP_CYCLES=4 instance: reset in the middle of a commit
        for (int k = 0; k < 3; k++) do_write_b(6'(k), 8'h01);
        apply_req_b = 1'b1;
        @(posedge clock);
        #1;
        apply_req_b = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock);
            #1;
            if (c == 3) check("b_pad0_before", pad_oe_b[0], 1'b0);
            if (c == 4) check("b_pad0_after", pad_oe_b[0], 1'b1);
            if (c == 7) check("b_pad1_before", pad_oe_b[1], 1'b0);
        end
        check("b_mid_state", {pad_oe_b[2:0], busy_b}, 4'b0111);
        reset_b = 1'b1;
        #1;
        check("b_rst_oe", pad_oe_b, '0);
        check("b_rst_ie", pad_ie_b, all_ones);
        check("b_rst_status", {cfg_ready_b, busy_b, apply_done_b, cfg_err_b}, 4'b1000);
        @(negedge clock);
        reset_b = 1'b0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (apply_done_b) n_done++;
        end
        check("b_no_resume", {pad_oe_b[2:0], busy_b, cfg_ready_b}, 5'b00001);
        check("b_no_done", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
